shift_reg4: RTL and testbench
=============================

SHIFT_REG4 -- requirements
Module: shift_reg4

Interface
REQ-001 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port ENB  input  1  enable; 0 = freeze all state.
REQ-004 SHALL have port DIR  input  1  shift direction; 1 = right (toward bit 0), 0 = left (toward bit 3).
REQ-005 SHALL have port S_IN  input  1  serial input bit for logical shift.
REQ-006 SHALL have port MODO  input  2  mode; 00 shift, 01 rotate, 10 parallel load, 11 hold.
REQ-007 SHALL have port D  input  4  parallel load data.
REQ-008 SHALL have port Q  output  4  register contents, registered.
REQ-009 SHALL have port S_OUT  output  1  last bit shifted out, registered.
REQ-010 SHALL have port CNT  output  2  shift/rotate steps since last load or reset, registered.
REQ-011 SHALL have port WRAP  output  1  one-cycle pulse on CNT wrap 3->0, registered.

Function
REQ-012 SHALL leave Q, S_OUT and CNT unchanged, and drive WRAP 0, on any edge with ENB=0, regardless of MODO.
REQ-013 SHALL, with ENB=1 and MODO=00, DIR=1: Q <= {S_IN, Q[3:1]}, S_OUT <= Q[0].
REQ-014 SHALL, with ENB=1 and MODO=00, DIR=0: Q <= {Q[2:0], S_IN}, S_OUT <= Q[3].
REQ-015 SHALL, with ENB=1 and MODO=01, DIR=1: Q <= {Q[0], Q[3:1]}, S_OUT <= Q[0]; S_IN ignored.
REQ-016 SHALL, with ENB=1 and MODO=01, DIR=0: Q <= {Q[2:0], Q[3]}, S_OUT <= Q[3]; S_IN ignored.
REQ-017 SHALL, with ENB=1 and MODO=10: Q <= D in one cycle, S_OUT unchanged, CNT <= 0, WRAP <= 0.
REQ-018 SHALL, with ENB=1 and MODO=11: Q, S_OUT, CNT unchanged, WRAP <= 0.
REQ-019 SHALL increment CNT by 1 modulo 4 on every enabled shift or rotate edge (MODO 00 or 01).
REQ-020 SHALL set WRAP to 1 for exactly the cycle following a step in which CNT goes 3->0; WRAP 0 otherwise.
REQ-021 SHALL produce results visible on Q/S_OUT/CNT/WRAP one clock edge after the sampling edge (latency 1); no combinational input-to-output paths.
REQ-022 SHALL honour a DIR or MODO change on the very next edge; no pipelining of controls.
REQ-023 SHALL guarantee that after 4 consecutive enabled rotates (either direction) Q equals its pre-rotate value and WRAP pulses if CNT started at 0.

Reset
REQ-024 SHALL, while RST_N=0, force Q=4'b0000, S_OUT=0, CNT=2'b00, WRAP=0 immediately, independent of CLK.
REQ-025 SHALL abandon any in-progress rotate sequence on reset; first enabled edge after RST_N rises operates on Q=0000, CNT=0.
REQ-026 SHALL use RST_N deassertion synchronous to CLK at system level; block adds no reset synchronizer.

Configuration
REQ-027 SHALL use macro SHREG_WRAP_CNT_EN: defined -> CNT/WRAP logic per REQ-017..020 compiled in.
REQ-028 SHALL, without SHREG_WRAP_CNT_EN, tie CNT to 2'b00 and WRAP to 0 and instantiate no counter flops; Q/S_OUT behaviour identical.

Verification
REQ-029 SHALL cover: reset, ENB=1, MODO=10, D=0001, one edge, then MODO=01, DIR=1, 4 edges -> Q 0001,1000,0100,0010,0001; S_OUT 1,0,0,0; WRAP=1 after 4th.
REQ-030 SHALL cover: Q=1011 loaded, MODO=00, DIR=0, S_IN=0, 2 edges -> Q 0110 then 1100; S_OUT 1 then 0; CNT 1,2.
REQ-031 SHALL cover: Q=0110, ENB=0, MODO=01, 3 edges -> Q stays 0110, CNT unchanged, WRAP 0.
REQ-032 SHALL cover: rotating with CNT=2, assert RST_N=0 between edges -> Q=0000, S_OUT=0, CNT=0 immediately without clock edge.
REQ-033 SHALL cover: CNT=3, MODO=10, D=1111 -> Q=1111, CNT=0, WRAP stays 0 (load beats wrap).
REQ-034 SHALL cover: build without SHREG_WRAP_CNT_EN, rerun REQ-029 -> identical Q/S_OUT, CNT=00 and WRAP=0 throughout.

Source files
------------

// File: rtl/shift_reg4_if.sv
// +----------------------------------------------------------------------------+
// | Module      : shift_reg4_if                                                |
// | Description : Control/data bundle for the 4-bit shift/rotate register.     |
// |               master drives ENB/DIR/S_IN/MODO/D and observes the outputs;  |
// |               slave (the register) consumes controls and drives Q, S_OUT,  |
// |               CNT and WRAP.                                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface shift_reg4_if;
  logic       ENB;    // 0 freezes all state
  logic       DIR;    // 1 = toward bit 0, 0 = toward bit 3
  logic       S_IN;   // serial input for logical shift
  logic [1:0] MODO;   // 00 shift, 01 rotate, 10 load, 11 hold
  logic [3:0] D;      // parallel load data
  logic [3:0] Q;      // register contents
  logic       S_OUT;  // last bit shifted/rotated out
  logic [1:0] CNT;    // steps since last load or reset
  logic       WRAP;   // one-cycle pulse after CNT wraps 3->0

  modport master (
    output ENB, DIR, S_IN, MODO, D,
    input  Q, S_OUT, CNT, WRAP
  );

  modport slave (
    input  ENB, DIR, S_IN, MODO, D,
    output Q, S_OUT, CNT, WRAP
  );
endinterface

`default_nettype wire

// File: rtl/shift_reg4.sv
// +----------------------------------------------------------------------------+
// | Module      : shift_reg4                                                   |
// | Description : 4-bit register with logical shift, rotate, parallel load    |
// |               and hold, plus an optional modulo-4 step counter with a     |
// |               wrap pulse. All outputs are registered (latency 1).          |
// | Ports       : CLK   - rising-edge clock                                    |
// |               RST_N - asynchronous active-low reset (deassertion assumed   |
// |                       synchronous to CLK at system level)                 |
// |               bus   - shift_reg4_if.slave (ENB, DIR, S_IN, MODO, D in;    |
// |                       Q, S_OUT, CNT, WRAP out)                             |
// | Config      : SHREG_WRAP_CNT_EN - when defined, CNT/WRAP counter logic is |
// |               built; otherwise CNT=00 and WRAP=0 with no counter flops.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift_reg4 (
  input  wire logic    CLK,
  input  wire logic    RST_N,
  shift_reg4_if.slave  bus
);

  localparam logic [1:0] c_mode_shift  = 2'b00;
  localparam logic [1:0] c_mode_rotate = 2'b01;
  localparam logic [1:0] c_mode_load   = 2'b10;
  localparam logic [1:0] c_mode_hold   = 2'b11;

  logic [3:0] q_q, q_d;
  logic       s_out_q, s_out_d;

  // Next-state for the data path. Shift and rotate differ only in what
  // enters the vacated end: S_IN for shift, the outgoing bit for rotate.
  always_comb begin
    q_d     = q_q;
    s_out_d = s_out_q;
    if (bus.ENB) begin
      case (bus.MODO)
        c_mode_shift: begin
          if (bus.DIR) begin
            q_d     = {bus.S_IN, q_q[3:1]};
            s_out_d = q_q[0];
          end else begin
            q_d     = {q_q[2:0], bus.S_IN};
            s_out_d = q_q[3];
          end
        end
        c_mode_rotate: begin
          if (bus.DIR) begin
            q_d     = {q_q[0], q_q[3:1]};
            s_out_d = q_q[0];
          end else begin
            q_d     = {q_q[2:0], q_q[3]};
            s_out_d = q_q[3];
          end
        end
        c_mode_load: begin
          q_d = bus.D;
        end
        c_mode_hold: begin
          q_d = q_q;
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q     <= 4'b0000;
      s_out_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      s_out_q <= s_out_d;
    end
  end

  assign bus.Q     = q_q;
  assign bus.S_OUT = s_out_q;

`ifdef SHREG_WRAP_CNT_EN
  logic [1:0] cnt_q, cnt_d;
  logic       wrap_q, wrap_d;

  // A load clears the count and suppresses the wrap pulse even when the
  // count is sitting at 3; only shift/rotate edges advance it.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.ENB) begin
      if (bus.MODO == c_mode_load) begin
        cnt_d = 2'b00;
      end else if (!bus.MODO[1]) begin
        cnt_d  = cnt_q + 2'd1;
        wrap_d = (cnt_q == 2'd3);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= 2'b00;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.CNT  = cnt_q;
  assign bus.WRAP = wrap_q;
`else
  assign bus.CNT  = 2'b00;
  assign bus.WRAP = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_reg4.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_shift_reg4                                                |
// | Description : Self-checking bench for shift_reg4: directed vector table,  |
// |               hand-written asynchronous reset sequence, and randomized    |
// |               stimulus against an arithmetic reference model. Counter     |
// |               expectations follow SHREG_WRAP_CNT_EN.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_shift_reg4;

`ifdef SHREG_WRAP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  shift_reg4_if bus ();

  shift_reg4 dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         enb;
    bit         dir;
    bit         sin;
    logic [1:0] modo;
    logic [3:0] d;
    logic [3:0] exp_q;
    bit         exp_sout;
    int         exp_cnt;   // value with the counter feature built in
    bit         exp_wrap;
  } vec_t;

  vec_t vecs[15];

  // Reference model state: value as an integer, total steps since load.
  int m_q;
  int m_sout;
  int m_steps;
  int m_wrap;

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input int q, input int sout,
                           input int cnt, input int wrap);
    check({tag, "_q"},    idx, int'(bus.Q),     q);
    check({tag, "_sout"}, idx, int'(bus.S_OUT), sout);
    check({tag, "_cnt"},  idx, int'(bus.CNT),   CNT_EN ? cnt : 0);
    check({tag, "_wrap"}, idx, int'(bus.WRAP),  CNT_EN ? wrap : 0);
  endtask

  task automatic apply(input bit enb, input bit dir, input bit sin,
                       input logic [1:0] modo, input logic [3:0] d);
    bus.ENB  = enb;
    bus.DIR  = dir;
    bus.S_IN = sin;
    bus.MODO = modo;
    bus.D    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input bit enb, input bit dir, input bit sin,
                            input int modo, input int d);
    int out_bit;
    if (!enb) begin
      m_wrap = 0;
    end else if (modo == 2) begin
      m_q = d; m_steps = 0; m_wrap = 0;
    end else if (modo == 3) begin
      m_wrap = 0;
    end else begin
      out_bit = dir ? (m_q % 2) : (m_q / 8);
      if (modo == 1) sin = out_bit[0];
      if (dir) m_q = m_q / 2 + (sin ? 8 : 0);
      else     m_q = (m_q * 2) % 16 + (sin ? 1 : 0);
      m_sout  = out_bit;
      m_steps = m_steps + 1;
      m_wrap  = (m_steps % 4 == 0) ? 1 : 0;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.ENB = 0; bus.DIR = 0; bus.S_IN = 0; bus.MODO = 2'b11; bus.D = 4'h0;

    // Directed sequence: load/rotate-right x4, load/shift-left x2,
    // shift-right, frozen rotates, load at CNT=3, hold, shift.
    vecs[0]  = '{1, 0, 0, 2'b10, 4'b0001, 4'b0001, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 2'b01, 4'b0000, 4'b1000, 1, 1, 0};
    vecs[2]  = '{1, 1, 1, 2'b01, 4'b0000, 4'b0100, 0, 2, 0};
    vecs[3]  = '{1, 1, 0, 2'b01, 4'b0000, 4'b0010, 0, 3, 0};
    vecs[4]  = '{1, 1, 1, 2'b01, 4'b0000, 4'b0001, 0, 0, 1};
    vecs[5]  = '{1, 0, 0, 2'b10, 4'b1011, 4'b1011, 0, 0, 0};
    vecs[6]  = '{1, 0, 0, 2'b00, 4'b0000, 4'b0110, 1, 1, 0};
    vecs[7]  = '{1, 0, 0, 2'b00, 4'b0000, 4'b1100, 0, 2, 0};
    vecs[8]  = '{1, 1, 0, 2'b00, 4'b0000, 4'b0110, 0, 3, 0};
    vecs[9]  = '{0, 1, 1, 2'b01, 4'b0000, 4'b0110, 0, 3, 0};
    vecs[10] = '{0, 0, 1, 2'b01, 4'b0000, 4'b0110, 0, 3, 0};
    vecs[11] = '{0, 1, 0, 2'b01, 4'b0000, 4'b0110, 0, 3, 0};
    vecs[12] = '{1, 0, 0, 2'b10, 4'b1111, 4'b1111, 0, 0, 0};
    vecs[13] = '{1, 1, 1, 2'b11, 4'b0000, 4'b1111, 0, 0, 0};
    vecs[14] = '{1, 1, 1, 2'b00, 4'b0000, 4'b1111, 1, 1, 0};

    // Reset state
    rst_n = 1'b0;
    #1;
    check_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].enb, vecs[i].dir, vecs[i].sin, vecs[i].modo, vecs[i].d);
      check_all("tbl", i, vecs[i].exp_q, vecs[i].exp_sout, vecs[i].exp_cnt, vecs[i].exp_wrap);
    end

    // Asynchronous reset in the middle of a rotate sequence.
    apply(1, 0, 0, 2'b10, 4'b1010);
    apply(1, 0, 0, 2'b01, 4'b0000);
    apply(1, 0, 0, 2'b01, 4'b0000);
    check_all("prerst", 0, 4'b1010, 0, 2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("asyncrst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 0, 1, 2'b00, 4'b0000);
    check_all("postrst", 0, 4'b0001, 0, 1, 0);

    // Four left rotates from a fresh load restore Q and pulse WRAP.
    apply(1, 0, 0, 2'b10, 4'b1101);
    for (int i = 0; i < 4; i++) apply(1, 0, 0, 2'b01, 4'b0000);
    check_all("rot4", 0, 4'b1101, 1, 0, 1);
    apply(0, 0, 0, 2'b01, 4'b0000);
    check_all("rot4_frz", 0, 4'b1101, 1, 0, 0);

    // Randomized run against the reference model from a known reset.
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    m_q = 0; m_sout = 0; m_steps = 0; m_wrap = 0;
    for (int i = 0; i < 400; i++) begin
      bit         enb, dir, sin;
      logic [1:0] modo;
      logic [3:0] d;
      enb  = ($urandom_range(0, 7) != 0);
      dir  = $urandom_range(0, 1) != 0;
      sin  = $urandom_range(0, 1) != 0;
      // Bias toward shift/rotate so the counter wraps frequently.
      modo = ($urandom_range(0, 9) < 7) ? 2'($urandom_range(0, 1))
                                        : 2'($urandom_range(2, 3));
      d    = 4'($urandom_range(0, 15));
      apply(enb, dir, sin, modo, d);
      model_step(enb, dir, sin, int'(modo), int'(d));
      check_all("rand", i, m_q, m_sout, m_steps % 4, m_wrap);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
